tl_vc_arbiter: RTL and testbench
================================

Name: tl_vc_arbiter

Overview:
- Downstream stage of the 4 per-VC input FIFOs (12-bit, push/pop, almost_full/almost_empty); sits between them and the 4 per-destination output FIFOs.
- Each cycle it picks one non-empty source FIFO round-robin and pops it.
- It captures the returned word and pushes it into the output FIFO chosen by the word's destination field.
- It stalls all popping while any output FIFO reports almost_full.

Parameters:
- WIDTH, 12, data word width in bits.
- DEST_LSB, 10, LSB of the 2-bit destination field; dest = data[DEST_LSB+1:DEST_LSB].

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
- src_data  input  4*WIDTH  data_out of source FIFO i at bits [i*WIDTH +: WIDTH]; valid in the cycle after FIFO i samples pop.
- src_empty  input  4  1 = source FIFO i holds no word.
- src_pop  output  4  one-hot or zero; pop to source FIFO i (registered).
- dst_almost_full  input  4  almost_full of output FIFO j.
- dst_push  output  4  one-hot or zero; push to output FIFO j (registered).
- dst_data  output  WIDTH  word for dst_push (registered).
- busy  output  1  1 while any word is in flight (pop issued, push not yet done).

Behaviour:
- Reset values:
  - src_pop = 0, dst_push = 0, dst_data = 0, busy = 0.
  - Round-robin pointer = 0; in-flight valid bits = 0.
- Reset mid-operation drops any in-flight word. No push is issued for it after reset deasserts.
- Pipeline: pop decision at edge k (src_pop high during cycle k+1) -> source FIFO updates data_out at edge k+1.
  - Edge k+1: rd_vld <= 1, rd_src <= i.
  - Edge k+2: dst_data <= src_data[rd_src], dst_push[dest] <= 1 (high during cycle k+3).
  - Latency pop-to-push = 2 cycles.
- Throughput: up to 1 word/cycle when alternating sources.
- Eligibility at each edge: src i is eligible iff src_empty[i] == 0 AND i was not popped at the previous edge.
  - The same-source mask covers the 1-cycle lag of the empty flag.
  - Result: max 1 pop per 2 cycles per source.
- Stall: no pop is issued at an edge where |dst_almost_full == 1.
  - Words already popped always complete their push (up to 2 in flight).
  - Output FIFOs must therefore leave >=2 free slots at almost_full.
- Round-robin:
  - Search starts at ptr and goes ptr, ptr+1, ... mod 4.
  - The first eligible source is granted; then ptr <= grant+1 (mod 4).
  - ptr is unchanged when there is no grant.
- dst_push is 0 in any cycle without a completing word; dst_data holds its last value.
- busy = rd_vld | (|src_pop) | (|dst_push).
- Destination field 3 is valid. Every dest value maps to exactly one output FIFO; no drops.

Optional Feature:
- Macro: TL_STRICT_PRIO_EN.
- Defined: strict priority, src0 highest, src3 lowest. Eligibility and the same-source mask are unchanged; ptr is ignored.
- Not defined: round-robin as above.

Decomposition:
- Shared include tl_defs.vh holds:
  - NUM_VC = 4.
  - WIDTH default 12.
  - DEST_LSB = 10.
  - The dest-field extraction macro.
- One sub-module: tl_rr_grant.
  - Combinational.
  - Inputs: eligible[3:0], ptr[1:0].
  - Outputs: one-hot grant[3:0] and grant index.
  - Contains the `ifdef TL_STRICT_PRIO_EN selection.

Test Plan:
- Reset: drive reset=0 mid-transfer (word popped, push pending) -> all outputs 0 immediately; no dst_push after release.
- Single source: src0 holds 3 words 0x0AB, 0x4CD, 0x8EF, others empty.
  - src_pop[0] pulses every other cycle.
  - dst_push = 0001, 0010, 0100 with dst_data matching, each 2 cycles after its pop.
- Round-robin fairness: all 4 sources non-empty -> pops in order 0, 1, 2, 3, 0 on consecutive cycles; one push per cycle after 2-cycle latency.
- Backpressure: raise dst_almost_full[2] while 2 words are in flight.
  - Both in-flight words are still pushed.
  - No further src_pop until almost_full clears; popping resumes on the next edge.
- Wrap/dest edge: src3 word 0xC00 with ptr=3 -> dest 3 gets push; ptr wraps to 0.
- Strict priority (with TL_STRICT_PRIO_EN): src0 and src2 each hold 2 words -> pop order 0, 2, 0, 2 (src0 masked on alternate cycles); without the macro the order is also 0, 2, 0, 2 from ptr=0.

Source files
------------

// File: rtl/tl_vc_arbiter_pkg.sv
// Shared constants and index helpers for the TL virtual-channel arbiter.
// Build option: define TL_STRICT_PRIO_EN for fixed priority (src0 highest) instead of round-robin.
package tl_vc_arbiter_pkg;

  localparam int NUM_VC           = 4;
  localparam int VC_IDX_W         = 2;
  localparam int WIDTH_DEFAULT    = 12;
  localparam int DEST_LSB_DEFAULT = 10;

  typedef logic [VC_IDX_W-1:0] vc_idx_t;
  typedef logic [NUM_VC-1:0]   vc_vec_t;

  function automatic vc_idx_t vc_onehot_to_idx(input vc_vec_t oh);
    vc_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (oh[i]) idx = vc_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic vc_vec_t vc_idx_to_onehot(input vc_idx_t idx);
    return vc_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/tl_rr_grant.sv
// Combinational grant picker: first eligible source searching upward from ptr_i (mod 4),
// or from source 0 when TL_STRICT_PRIO_EN is defined.
module tl_rr_grant
  import tl_vc_arbiter_pkg::*;
(
  input  logic [NUM_VC-1:0]   eligible_i,
  input  logic [VC_IDX_W-1:0] ptr_i,
  output logic [NUM_VC-1:0]   grant_o,
  output logic [VC_IDX_W-1:0] grant_idx_o,
  output logic                grant_vld_o
);

  vc_idx_t start_idx;
  vc_idx_t cand_idx;
  logic    found;

`ifdef TL_STRICT_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  assign start_idx  = '0;
`else
  assign start_idx  = ptr_i;
`endif

  // 2-bit index arithmetic gives the mod-4 wrap for free.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand_idx    = '0;
    for (int off = 0; off < NUM_VC; off++) begin
      cand_idx = start_idx + vc_idx_t'(off);
      if (!found && eligible_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        grant_idx_o       = cand_idx;
      end
    end
    grant_vld_o = found;
  end

endmodule

// File: rtl/tl_vc_arbiter.sv
// Pops one non-empty source FIFO per edge and forwards the word to the output FIFO named by its dest field.
// Build option: TL_STRICT_PRIO_EN selects strict priority in tl_rr_grant.
module tl_vc_arbiter
  import tl_vc_arbiter_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int DEST_LSB = DEST_LSB_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_VC*WIDTH-1:0] src_data,
  input  logic [NUM_VC-1:0]       src_empty,
  output logic [NUM_VC-1:0]       src_pop,
  input  logic [NUM_VC-1:0]       dst_almost_full,
  output logic [NUM_VC-1:0]       dst_push,
  output logic [WIDTH-1:0]        dst_data,
  output logic                    busy
);

  logic [WIDTH-1:0] src_word [NUM_VC];

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_unpack
    assign src_word[gi] = src_data[gi*WIDTH +: WIDTH];
  end

  vc_vec_t          src_pop_q,  src_pop_d;
  vc_idx_t          ptr_q,      ptr_d;
  logic             rd_vld_q,   rd_vld_d;
  vc_idx_t          rd_src_q,   rd_src_d;
  vc_vec_t          dst_push_q, dst_push_d;
  logic [WIDTH-1:0] dst_data_q, dst_data_d;

  vc_vec_t          eligible;
  vc_vec_t          grant;
  vc_idx_t          grant_idx;
  logic             grant_vld;
  logic             stall;
  logic [WIDTH-1:0] rd_word;
  vc_idx_t          rd_dest;

  // A source popped last edge still shows its pre-pop empty flag, so mask it for one edge.
  assign eligible = ~src_empty & ~src_pop_q;
  assign stall    = |dst_almost_full;

  tl_rr_grant u_grant (
    .eligible_i  (eligible),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  assign rd_word = src_word[rd_src_q];
  assign rd_dest = rd_word[DEST_LSB +: VC_IDX_W];

  always_comb begin
    src_pop_d  = '0;
    ptr_d      = ptr_q;
    if (!stall && grant_vld) begin
      src_pop_d = grant;
      ptr_d     = grant_idx + vc_idx_t'(1);
    end
    rd_vld_d   = |src_pop_q;
    rd_src_d   = vc_onehot_to_idx(src_pop_q);
    dst_push_d = '0;
    dst_data_d = dst_data_q;
    if (rd_vld_q) begin
      dst_push_d = vc_idx_to_onehot(rd_dest);
      dst_data_d = rd_word;
    end
  end

  // Stall never gates the later stages: anything already popped always completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_pop_q  <= '0;
      ptr_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_src_q   <= '0;
      dst_push_q <= '0;
      dst_data_q <= '0;
    end else begin
      src_pop_q  <= src_pop_d;
      ptr_q      <= ptr_d;
      rd_vld_q   <= rd_vld_d;
      rd_src_q   <= rd_src_d;
      dst_push_q <= dst_push_d;
      dst_data_q <= dst_data_d;
    end
  end

  assign src_pop  = src_pop_q;
  assign dst_push = dst_push_q;
  assign dst_data = dst_data_q;
  assign busy     = rd_vld_q | (|src_pop_q) | (|dst_push_q);

endmodule

// File: tb/tb_tl_vc_arbiter.sv
// Bench for tl_vc_arbiter: behavioural source FIFOs plus a transaction-level reference model.
module tb_tl_vc_arbiter;

  localparam int W = 12;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [4*W-1:0] src_data;
  logic [3:0]     src_empty = 4'hF;
  logic [3:0]     src_pop;
  logic [3:0]     dst_almost_full = 4'h0;
  logic [3:0]     dst_push;
  logic [W-1:0]   dst_data;
  logic           busy;

  int checks = 0;
  int failures = 0;

  tl_vc_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .src_data        (src_data),
    .src_empty       (src_empty),
    .src_pop         (src_pop),
    .dst_almost_full (dst_almost_full),
    .dst_push        (dst_push),
    .dst_data        (dst_data),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Source FIFOs: every word ever loaded is kept in hist; fifo_rd is the read pointer.
  logic [W-1:0] hist [4][256];
  int           hist_wr [4];
  int           fifo_rd [4];
  logic [W-1:0] src_word [4] = '{default: '0};

  assign src_data = {src_word[3], src_word[2], src_word[1], src_word[0]};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (src_pop[i] && fifo_rd[i] < hist_wr[i]) begin
        src_word[i] <= hist[i][fifo_rd[i]];
        fifo_rd[i] = fifo_rd[i] + 1;
      end
      src_empty[i] <= (fifo_rd[i] == hist_wr[i]);
    end
  end

  // Reference model: a pop at edge n yields a push of the same word at edge n+2.
  typedef struct {
    int           due;
    logic [W-1:0] word;
  } push_t;

  push_t        push_due[$];
  int           taken [4];
  int           cyc = 0;
  int           m_ptr = 0;
  int           m_last = -1;
  int           m_g;
  int           m_idx;
  logic [3:0]   exp_src_pop = '0;
  logic [3:0]   exp_dst_push = '0;
  logic [W-1:0] exp_dst_data = '0;
  logic         exp_busy = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_due.delete();
      m_ptr = 0;
      m_last = -1;
      exp_src_pop = '0;
      exp_dst_push = '0;
      exp_dst_data = '0;
      exp_busy = 1'b0;
      for (int i = 0; i < 4; i++) taken[i] = fifo_rd[i];
    end else begin
      cyc = cyc + 1;
      m_g = -1;
      if (dst_almost_full == 4'h0) begin
        for (int off = 0; off < 4; off++) begin
`ifdef TL_STRICT_PRIO_EN
          m_idx = off;
`else
          m_idx = (m_ptr + off) % 4;
`endif
          if (m_g < 0 && !src_empty[m_idx] && m_idx != m_last) m_g = m_idx;
        end
      end
      m_last = m_g;
      exp_src_pop = '0;
      exp_dst_push = '0;
      if (m_g >= 0) begin
        m_ptr = (m_g + 1) % 4;
        push_due.push_back('{cyc + 2, hist[m_g][taken[m_g]]});
        taken[m_g] = taken[m_g] + 1;
        exp_src_pop[m_g] = 1'b1;
      end
      if (push_due.size() > 0 && push_due[0].due == cyc) begin
        exp_dst_push[push_due[0].word[11:10]] = 1'b1;
        exp_dst_data = push_due[0].word;
        void'(push_due.pop_front());
      end
      exp_busy = (push_due.size() != 0) || (exp_dst_push != 4'h0);
    end
  end

  function automatic int first_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic load(input int s, input logic [W-1:0] w);
    if (hist_wr[s] < 256) begin
      hist[s][hist_wr[s]] = w;
      hist_wr[s] = hist_wr[s] + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bit got_pop;
    @(negedge clk);
    checks++;
    if ({src_pop, dst_push, dst_data, busy} !== 21'h0) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=0", {src_pop, dst_push, dst_data, busy});
    end
    reset = 1'b1;
    load(1, 12'hC3C);
    got_pop = 0;
    for (int c = 0; c < 10 && !got_pop; c++) begin
      @(negedge clk);
      checks++;
      if ({src_pop, dst_push, dst_data, busy} !== {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy}) begin
        failures++;
        $display("FAIL reset_pre got=%h exp=%h", {src_pop, dst_push, dst_data, busy}, {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy});
      end
      got_pop = (src_pop != 4'h0);
    end
    checks++;
    if (!got_pop) begin
      failures++;
      $display("FAIL reset_wait_pop got=none exp=pop within 10 cycles");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy_inflight got=%b exp=1", busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({src_pop, dst_push, dst_data, busy} !== 21'h0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", {src_pop, dst_push, dst_data, busy});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (dst_push !== 4'h0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_dropped cyc=%0d got push=%b busy=%b exp push=0000 busy=0", c, dst_push, busy);
      end
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single_source();
    int           pop_c[$];
    int           push_c[$];
    logic [3:0]   pop_v[$];
    logic [3:0]   push_v[$];
    logic [W-1:0] push_d[$];
    logic [3:0]   exp_v [3];
    logic [W-1:0] exp_d [3];
    exp_v = '{4'b0001, 4'b0010, 4'b0100};
    exp_d = '{12'h0AB, 12'h4CD, 12'h8EF};
    do_reset();
    for (int k = 0; k < 3; k++) load(0, exp_d[k]);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      checks++;
      if ({src_pop, dst_push, dst_data, busy} !== {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy}) begin
        failures++;
        $display("FAIL single_model cyc=%0d got=%h exp=%h", c, {src_pop, dst_push, dst_data, busy}, {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy});
      end
      if (src_pop != 4'h0) begin pop_c.push_back(c); pop_v.push_back(src_pop); end
      if (dst_push != 4'h0) begin push_c.push_back(c); push_v.push_back(dst_push); push_d.push_back(dst_data); end
    end
    checks++;
    if (pop_c.size() != 3 || push_c.size() != 3) begin
      failures++;
      $display("FAIL single_count got pops=%0d pushes=%0d exp 3/3", pop_c.size(), push_c.size());
    end
    for (int k = 0; k < 3 && k < pop_c.size() && k < push_c.size(); k++) begin
      checks++;
      if (pop_v[k] !== 4'b0001 || push_v[k] !== exp_v[k] || push_d[k] !== exp_d[k] || push_c[k] - pop_c[k] != 2) begin
        failures++;
        $display("FAIL single_word%0d got pop=%b push=%b data=%h lat=%0d exp pop=0001 push=%b data=%h lat=2",
                 k, pop_v[k], push_v[k], push_d[k], push_c[k] - pop_c[k], exp_v[k], exp_d[k]);
      end
      if (k > 0) begin
        checks++;
        if (pop_c[k] - pop_c[k-1] != 2) begin
          failures++;
          $display("FAIL single_spacing%0d got=%0d exp=2", k, pop_c[k] - pop_c[k-1]);
        end
      end
    end
    $display("test_single_source done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_round_robin();
    int order[$];
    int push_c[$];
    int exp_order [5];
`ifdef TL_STRICT_PRIO_EN
    exp_order = '{0, 1, 0, 1, 2};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    for (int s = 0; s < 4; s++) begin
      load(s, W'($urandom_range(0, 4095)));
      load(s, W'($urandom_range(0, 4095)));
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if ({src_pop, dst_push, dst_data, busy} !== {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy}) begin
        failures++;
        $display("FAIL rr_model cyc=%0d got=%h exp=%h", c, {src_pop, dst_push, dst_data, busy}, {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy});
      end
      if (src_pop != 4'h0) order.push_back(first_idx(src_pop));
      if (dst_push != 4'h0) push_c.push_back(c);
    end
    for (int k = 0; k < 5 && k < order.size(); k++) begin
      checks++;
      if (order[k] != exp_order[k]) begin
        failures++;
        $display("FAIL rr_order%0d got=%0d exp=%0d", k, order[k], exp_order[k]);
      end
    end
    checks++;
    if (push_c.size() != 8 || push_c[push_c.size()-1] - push_c[0] != 7) begin
      failures++;
      $display("FAIL rr_push_rate got pushes=%0d exp 8 on consecutive cycles", push_c.size());
    end
    $display("test_round_robin done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_backpressure();
    bit prev_pop;
    bit got;
    int npush;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      load(0, W'($urandom_range(0, 4095)));
      load(1, W'($urandom_range(0, 4095)));
    end
    prev_pop = 0;
    got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      checks++;
      if ({src_pop, dst_push, dst_data, busy} !== {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy}) begin
        failures++;
        $display("FAIL bp_model_pre cyc=%0d got=%h exp=%h", c, {src_pop, dst_push, dst_data, busy}, {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy});
      end
      got = prev_pop && (src_pop != 4'h0);
      prev_pop = (src_pop != 4'h0);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL bp_inflight got=none exp=two consecutive pops within 12 cycles");
    end
    dst_almost_full = 4'b0100;
    npush = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (src_pop !== 4'h0 || {dst_push, dst_data, busy} !== {exp_dst_push, exp_dst_data, exp_busy}) begin
        failures++;
        $display("FAIL bp_stall cyc=%0d got pop=%b push=%b data=%h exp pop=0000 push=%b data=%h", c, src_pop, dst_push, dst_data, exp_dst_push, exp_dst_data);
      end
      if (dst_push != 4'h0) npush++;
    end
    checks++;
    if (npush != 2) begin
      failures++;
      $display("FAIL bp_drain got=%0d exp=2", npush);
    end
    dst_almost_full = 4'h0;
    @(negedge clk);
    checks++;
    if (src_pop == 4'h0) begin
      failures++;
      $display("FAIL bp_resume got=%b exp=nonzero", src_pop);
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if ({src_pop, dst_push, dst_data, busy} !== {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy}) begin
        failures++;
        $display("FAIL bp_model_post cyc=%0d got=%h exp=%h", c, {src_pop, dst_push, dst_data, busy}, {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy});
      end
    end
    $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_wrap_dest();
    bit found;
    int order[$];
    do_reset();
    load(2, 12'h123);
    load(3, 12'hC00);
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({src_pop, dst_push, dst_data, busy} !== {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy}) begin
        failures++;
        $display("FAIL wrap_model cyc=%0d got=%h exp=%h", c, {src_pop, dst_push, dst_data, busy}, {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy});
      end
      if (dst_push == 4'b1000 && dst_data == 12'hC00) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wrap_dest3 got=none exp push=1000 data=c00");
    end
    load(3, 12'hC11);
    load(0, 12'h011);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if ({src_pop, dst_push, dst_data, busy} !== {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy}) begin
        failures++;
        $display("FAIL wrap_model2 cyc=%0d got=%h exp=%h", c, {src_pop, dst_push, dst_data, busy}, {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy});
      end
      if (src_pop != 4'h0) order.push_back(first_idx(src_pop));
    end
    checks++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 3) begin
      failures++;
      $display("FAIL wrap_ptr got pops=%0d first=%0d exp pops=2 order 0,3", order.size(), (order.size() > 0) ? order[0] : -1);
    end
    $display("test_wrap_dest done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_strict_prio();
    int order[$];
    int exp_order [4];
    exp_order = '{0, 2, 0, 2};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      load(0, W'($urandom_range(0, 4095)));
      load(2, W'($urandom_range(0, 4095)));
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({src_pop, dst_push, dst_data, busy} !== {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy}) begin
        failures++;
        $display("FAIL prio_model cyc=%0d got=%h exp=%h", c, {src_pop, dst_push, dst_data, busy}, {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy});
      end
      if (src_pop != 4'h0) order.push_back(first_idx(src_pop));
    end
    checks++;
    if (order.size() != 4) begin
      failures++;
      $display("FAIL prio_count got=%0d exp=4", order.size());
    end
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      checks++;
      if (order[k] != exp_order[k]) begin
        failures++;
        $display("FAIL prio_order%0d got=%0d exp=%0d", k, order[k], exp_order[k]);
      end
    end
    $display("test_strict_prio done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c < 500 && $urandom_range(0, 99) < 45) load($urandom_range(0, 3), W'($urandom_range(0, 4095)));
      dst_almost_full = (c < 500 && $urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      @(negedge clk);
      checks++;
      if ({src_pop, dst_push, dst_data, busy} !== {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy}) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", c, {src_pop, dst_push, dst_data, busy}, {exp_src_pop, exp_dst_push, exp_dst_data, exp_busy});
      end
    end
    dst_almost_full = 4'h0;
    checks++;
    if (busy !== 1'b0 || src_empty !== 4'hF) begin
      failures++;
      $display("FAIL random_drained got busy=%b empty=%b exp busy=0 empty=1111", busy, src_empty);
    end
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_wrap_dest();
    test_strict_prio();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
